nes_calc_core: RTL and testbench

Parametrised calculator control core that turns polled NES controller buttons into operand entry, add/subtract execution and a display value.
- Sits between the NES controller reader (button levels plus a per-poll strobe) and the seven-segment driver.
- Replaces the fixed-width combinational add/sub/mux path with a registered, mode-selectable datapath.
- Adds edge-detected button handling and an entry state machine.

---
 rtl/nes_calc_pkg.sv | 28 ++
 rtl/nes_calc_core_btn_edge.sv | 31 +++
 rtl/nes_calc_core.sv | 187 ++++++++++++++++++
 tb/tb_nes_calc_core.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_calc_pkg.sv
// Shared types and constants for the NES-controller calculator core.
package nes_calc_pkg;

    // Entry state machine states
    typedef enum logic [1:0] {
        EDIT_A = 2'd0,
        EDIT_B = 2'd1,
        CALC   = 2'd2,
        SHOW   = 2'd3
    } state_t;

    // Arithmetic operation selected by the A/B buttons
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Bit positions of each button inside the packed button vector
    localparam int NUM_BTNS   = 7;
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_SELECT = 4;
    localparam int BTN_A      = 5;
    localparam int BTN_B      = 6;

endpackage

// File: rtl/nes_calc_core_btn_edge.sv
// Strobe-qualified rising-edge detector: a held button yields one press only.
module nes_btn_edge #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         strobe_i,
    input  logic [N-1:0] sample_i,
    output logic [N-1:0] press_o
);

    logic [N-1:0] prev_q;

    // Remember the last polled levels; only a completed poll updates them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else if (strobe_i) begin
            prev_q <= sample_i;
        end
    end

    // A press is a button newly high in this poll compared with the previous poll
    always_comb begin
        press_o = '0;
        if (strobe_i) begin
            press_o = sample_i & ~prev_q;
        end
    end

endmodule

// File: rtl/nes_calc_core.sv
// Calculator control core: button presses drive operand entry, add/sub and display.
module nes_calc_core
    import nes_calc_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_valid,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_select,
    input  logic             btn_a,
    input  logic             btn_b,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    output logic             carry,
    output logic             negative,
    output logic             edit_b,
    output logic [WIDTH:0]   disp_value
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [NUM_BTNS-1:0] btnSample;
    logic [NUM_BTNS-1:0] press;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [WIDTH-1:0]  operandA_q, operandA_d;
    logic [WIDTH-1:0]  operandB_q, operandB_d;
    logic [WIDTH:0]    result_q, result_d;
    logic              carry_q, carry_d;
    logic              negative_q, negative_d;
    logic              resultValid_q, resultValid_d;

    logic [WIDTH:0]    addRes;
    logic [WIDTH:0]    subRes;

    assign btnSample = {btn_b, btn_a, btn_select, btn_right, btn_left, btn_down, btn_up};

    nes_btn_edge #(
        .N (NUM_BTNS)
    ) uEdge (
        .clk      (clk),
        .reset_n  (reset_n),
        .strobe_i (btn_valid),
        .sample_i (btnSample),
        .press_o  (press)
    );

    // Operand increment: wraps modulo 2^WIDTH unless clamping is enabled
    function automatic logic [WIDTH-1:0] stepUp(input logic [WIDTH-1:0] v);
        if (SATURATE != 0 && v == MAX_VAL) begin
            return v;
        end
        return v + ONE;
    endfunction

    // Operand decrement: wraps to all-ones unless clamping holds it at zero
    function automatic logic [WIDTH-1:0] stepDown(input logic [WIDTH-1:0] v);
        if (SATURATE != 0 && v == '0) begin
            return v;
        end
        return v - ONE;
    endfunction

    assign addRes = {1'b0, operandA_q} + {1'b0, operandB_q};
    assign subRes = {1'b0, operandA_q} - {1'b0, operandB_q};

    // Next-state logic: one prioritised action per poll, CALC always takes one cycle
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        operandA_d    = operandA_q;
        operandB_d    = operandB_q;
        result_d      = result_q;
        carry_d       = carry_q;
        negative_d    = negative_q;
        resultValid_d = 1'b0;

        if (state_q == CALC) begin
            // Presses arriving now are dropped; the edge detector still records levels
            if (op_q == OP_ADD) begin
                result_d   = addRes;
                carry_d    = addRes[WIDTH];
                negative_d = 1'b0;
            end else begin
                result_d   = subRes;
                carry_d    = 1'b0;
                negative_d = (operandA_q < operandB_q);
            end
            resultValid_d = 1'b1;
            state_d       = SHOW;
        end else if (press[BTN_SELECT]) begin
            operandA_d = '0;
            operandB_d = '0;
            result_d   = '0;
            carry_d    = 1'b0;
            negative_d = 1'b0;
            state_d    = EDIT_A;
        end else if (press[BTN_A]) begin
            op_d    = OP_ADD;
            state_d = CALC;
        end else if (press[BTN_B]) begin
            op_d    = OP_SUB;
            state_d = CALC;
        end else begin
            unique case (state_q)
                EDIT_A: begin
                    if (press[BTN_RIGHT]) begin
                        state_d = EDIT_B;
                    end else if (press[BTN_UP]) begin
                        operandA_d = stepUp(operandA_q);
                    end else if (press[BTN_DOWN]) begin
                        operandA_d = stepDown(operandA_q);
                    end
                end
                EDIT_B: begin
                    if (press[BTN_LEFT]) begin
                        state_d = EDIT_A;
                    end else if (press[BTN_UP]) begin
                        operandB_d = stepUp(operandB_q);
                    end else if (press[BTN_DOWN]) begin
                        operandB_d = stepDown(operandB_q);
                    end
                end
                SHOW: begin
                    if (|press[BTN_RIGHT:BTN_UP]) begin
                        state_d = EDIT_A;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= EDIT_A;
            op_q          <= OP_ADD;
            operandA_q    <= '0;
            operandB_q    <= '0;
            result_q      <= '0;
            carry_q       <= 1'b0;
            negative_q    <= 1'b0;
            resultValid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            operandA_q    <= operandA_d;
            operandB_q    <= operandB_d;
            result_q      <= result_d;
            carry_q       <= carry_d;
            negative_q    <= negative_d;
            resultValid_q <= resultValid_d;
        end
    end

    // Display follows the operand being edited, otherwise the last result
    always_comb begin
        disp_value = result_q;
        if (state_q == EDIT_A) begin
            disp_value = {1'b0, operandA_q};
        end else if (state_q == EDIT_B) begin
            disp_value = {1'b0, operandB_q};
        end
    end

    assign operand_a    = operandA_q;
    assign operand_b    = operandB_q;
    assign result       = result_q;
    assign result_valid = resultValid_q;
    assign carry        = carry_q;
    assign negative     = negative_q;
    assign edit_b       = (state_q == EDIT_B);

endmodule

// File: tb/tb_nes_calc_core.sv
// Scoreboard bench for nes_calc_core: one wrapping and one clamping instance share stimulus.
module tb_nes_calc_core;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;
    localparam int RMOD  = 1 << (WIDTH + 1);

    // Mode numbering private to the reference model
    localparam int M_EDA  = 0;
    localparam int M_EDB  = 1;
    localparam int M_CALC = 2;
    localparam int M_SHOW = 3;

    // Button vector layout used by the bench
    localparam logic [6:0] K_UP = 7'h01;
    localparam logic [6:0] K_DN = 7'h02;
    localparam logic [6:0] K_LF = 7'h04;
    localparam logic [6:0] K_RT = 7'h08;
    localparam logic [6:0] K_SL = 7'h10;
    localparam logic [6:0] K_A  = 7'h20;
    localparam logic [6:0] K_B  = 7'h40;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic btn_valid = 1'b0;
    logic bUp = 1'b0, bDown = 1'b0, bLeft = 1'b0, bRight = 1'b0;
    logic bSelect = 1'b0, bA = 1'b0, bB = 1'b0;

    logic [WIDTH-1:0] opA [2];
    logic [WIDTH-1:0] opB [2];
    logic [WIDTH:0]   res [2];
    logic [WIDTH:0]   disp [2];
    logic             rv [2];
    logic             cy [2];
    logic             ng [2];
    logic             eb [2];

    typedef struct {
        int idx; int a; int b; int editB; int disp; int res; int carry; int neg;
    } snap_t;

    typedef struct {
        int idx; int res; int carry; int neg;
    } resexp_t;

    snap_t   pollQ[$];
    resexp_t resQ[$];

    int checks = 0;
    int errors = 0;

    int mA [2], mB [2], mRes [2], mCarry [2], mNeg [2], mMode [2], mSub [2];
    logic [6:0] mPrev [2];

    always #5 clk = ~clk;

    nes_calc_core #(.WIDTH(WIDTH), .SATURATE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .btn_valid(btn_valid),
        .btn_up(bUp), .btn_down(bDown), .btn_left(bLeft), .btn_right(bRight),
        .btn_select(bSelect), .btn_a(bA), .btn_b(bB),
        .operand_a(opA[0]), .operand_b(opB[0]), .result(res[0]),
        .result_valid(rv[0]), .carry(cy[0]), .negative(ng[0]),
        .edit_b(eb[0]), .disp_value(disp[0])
    );

    nes_calc_core #(.WIDTH(WIDTH), .SATURATE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .btn_valid(btn_valid),
        .btn_up(bUp), .btn_down(bDown), .btn_left(bLeft), .btn_right(bRight),
        .btn_select(bSelect), .btn_a(bA), .btn_b(bB),
        .operand_a(opA[1]), .operand_b(opB[1]), .result(res[1]),
        .result_valid(rv[1]), .carry(cy[1]), .negative(ng[1]),
        .edit_b(eb[1]), .disp_value(disp[1])
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int upVal(input int v, input int sat);
        if (v == MAXV) return (sat != 0) ? MAXV : 0;
        return v + 1;
    endfunction

    function automatic int downVal(input int v, input int sat);
        if (v == 0) return (sat != 0) ? 0 : MAXV;
        return v - 1;
    endfunction

    function automatic void modelReset();
        for (int k = 0; k < 2; k++) begin
            mA[k] = 0; mB[k] = 0; mRes[k] = 0; mCarry[k] = 0; mNeg[k] = 0;
            mMode[k] = M_EDA; mSub[k] = 0; mPrev[k] = '0;
        end
        pollQ.delete();
        resQ.delete();
    endfunction

    // Advance the reference by one clock edge; k==1 is the clamping instance
    function automatic void modelStep(input bit valid, input logic [6:0] btns);
        logic [6:0] p;
        snap_t s;
        resexp_t r;
        for (int k = 0; k < 2; k++) begin
            if (mMode[k] == M_CALC) begin
                if (mSub[k] == 0) begin
                    mRes[k] = mA[k] + mB[k];
                    mCarry[k] = (mRes[k] > MAXV) ? 1 : 0;
                    mNeg[k] = 0;
                end else begin
                    mRes[k] = ((mA[k] - mB[k]) + RMOD) % RMOD;
                    mNeg[k] = (mA[k] < mB[k]) ? 1 : 0;
                    mCarry[k] = 0;
                end
                mMode[k] = M_SHOW;
                r.idx = k; r.res = mRes[k]; r.carry = mCarry[k]; r.neg = mNeg[k];
                resQ.push_back(r);
                if (valid) mPrev[k] = btns;
            end else if (valid) begin
                p = btns & ~mPrev[k];
                mPrev[k] = btns;
                if (p[4]) begin
                    mA[k] = 0; mB[k] = 0; mRes[k] = 0; mCarry[k] = 0; mNeg[k] = 0;
                    mMode[k] = M_EDA;
                end else if (p[5]) begin
                    mSub[k] = 0; mMode[k] = M_CALC;
                end else if (p[6]) begin
                    mSub[k] = 1; mMode[k] = M_CALC;
                end else if (mMode[k] == M_SHOW) begin
                    if (p[3:0] != 4'b0) mMode[k] = M_EDA;
                end else if (mMode[k] == M_EDA) begin
                    if (p[3]) mMode[k] = M_EDB;
                    else if (p[0]) mA[k] = upVal(mA[k], k);
                    else if (p[1]) mA[k] = downVal(mA[k], k);
                end else begin
                    if (p[2]) mMode[k] = M_EDA;
                    else if (p[0]) mB[k] = upVal(mB[k], k);
                    else if (p[1]) mB[k] = downVal(mB[k], k);
                end
            end
            if (valid) begin
                s.idx = k; s.a = mA[k]; s.b = mB[k];
                s.editB = (mMode[k] == M_EDB) ? 1 : 0;
                s.disp = (mMode[k] == M_EDA) ? mA[k] : ((mMode[k] == M_EDB) ? mB[k] : mRes[k]);
                s.res = mRes[k]; s.carry = mCarry[k]; s.neg = mNeg[k];
                pollQ.push_back(s);
            end
        end
    endfunction

    // Drive one cycle of stimulus on the falling edge and predict the coming rising edge
    task automatic applyStimulus(input bit valid, input logic [6:0] btns);
        @(negedge clk);
        btn_valid = valid;
        bUp = btns[0]; bDown = btns[1]; bLeft = btns[2]; bRight = btns[3];
        bSelect = btns[4]; bA = btns[5]; bB = btns[6];
        modelStep(valid, btns);
    endtask

    task automatic press(input logic [6:0] btns);
        applyStimulus(1'b1, btns);
        applyStimulus(1'b1, 7'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 7'h00);
    endtask

    task automatic checkAllZero(input string tag);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s dut%0d operand_a", tag, k), opA[k], 0);
            checkOutput($sformatf("%s dut%0d operand_b", tag, k), opB[k], 0);
            checkOutput($sformatf("%s dut%0d result", tag, k), res[k], 0);
            checkOutput($sformatf("%s dut%0d result_valid", tag, k), rv[k], 0);
            checkOutput($sformatf("%s dut%0d carry", tag, k), cy[k], 0);
            checkOutput($sformatf("%s dut%0d negative", tag, k), ng[k], 0);
            checkOutput($sformatf("%s dut%0d edit_b", tag, k), eb[k], 0);
            checkOutput($sformatf("%s dut%0d disp_value", tag, k), disp[k], 0);
        end
    endtask

    // Monitor: after every rising edge compare poll snapshots and result pulses
    always begin : monitor
        bit sawValid;
        snap_t s;
        resexp_t r;
        @(posedge clk);
        sawValid = btn_valid;
        #1;
        if (reset_n) begin
            if (sawValid) begin
                for (int k = 0; k < 2; k++) begin
                    if (pollQ.size() == 0) begin
                        checkOutput($sformatf("dut%0d poll expectation present", k), 0, 1);
                    end else begin
                        s = pollQ.pop_front();
                        checkOutput($sformatf("dut%0d operand_a", k), opA[k], s.a);
                        checkOutput($sformatf("dut%0d operand_b", k), opB[k], s.b);
                        checkOutput($sformatf("dut%0d edit_b", k), eb[k], s.editB);
                        checkOutput($sformatf("dut%0d disp_value", k), disp[k], s.disp);
                        checkOutput($sformatf("dut%0d held result", k), res[k], s.res);
                        checkOutput($sformatf("dut%0d held carry", k), cy[k], s.carry);
                        checkOutput($sformatf("dut%0d held negative", k), ng[k], s.neg);
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (rv[k] === 1'b1) begin
                    if (resQ.size() == 0 || resQ[0].idx != k) begin
                        checkOutput($sformatf("dut%0d unexpected result_valid", k), 1, 0);
                    end else begin
                        r = resQ.pop_front();
                        checkOutput($sformatf("dut%0d result", k), res[k], r.res);
                        checkOutput($sformatf("dut%0d carry", k), cy[k], r.carry);
                        checkOutput($sformatf("dut%0d negative", k), ng[k], r.neg);
                    end
                end else if (resQ.size() != 0 && resQ[0].idx == k) begin
                    // Expected pulse for this edge did not appear
                    r = resQ.pop_front();
                    checkOutput($sformatf("dut%0d result_valid pulse", k), rv[k], 1);
                end
            end
        end
    end

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [6:0] rb;
        bit rvld;
        modelReset();
        #1 reset_n = 1'b0;
        #1 checkAllZero("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] test 1: 3+2");
        for (int i = 0; i < 3; i++) press(K_UP);
        press(K_RT);
        for (int i = 0; i < 2; i++) press(K_UP);
        applyStimulus(1'b1, K_A);
        idle(2);
        checkOutput("t1 operand_a", opA[0], 3);
        checkOutput("t1 operand_b", opB[0], 2);
        checkOutput("t1 result", res[0], 5);
        checkOutput("t1 carry", cy[0], 0);
        applyStimulus(1'b1, 7'h00);

        $display("[TB] test 2: 9+12 then 9-12");
        press(K_SL);
        for (int i = 0; i < 9; i++) press(K_UP);
        press(K_RT);
        for (int i = 0; i < 12; i++) press(K_UP);
        press(K_A);
        idle(1);
        checkOutput("t2 add result", res[0], 5'b10101);
        checkOutput("t2 add carry", cy[0], 1);
        press(K_B);
        idle(1);
        checkOutput("t2 sub result", res[0], 5'b11101);
        checkOutput("t2 sub negative", ng[0], 1);
        checkOutput("t2 sub carry", cy[0], 0);

        $display("[TB] test 3: boundaries");
        press(K_SL);
        press(K_DN);
        checkOutput("t3 wrap down", opA[0], 15);
        checkOutput("t3 clamp down", opA[1], 0);
        press(K_SL);
        for (int i = 0; i < 15; i++) press(K_UP);
        press(K_UP);
        checkOutput("t3 wrap up", opA[0], 0);
        checkOutput("t3 clamp up", opA[1], 15);

        $display("[TB] test 4: edges and priority");
        press(K_SL);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, K_UP);
        applyStimulus(1'b1, 7'h00);
        checkOutput("t4 held up", opA[0], 1);
        press(K_UP | K_DN);
        checkOutput("t4 up over down", opA[0], 2);
        press(K_SL | K_A);
        idle(2);
        checkOutput("t4 select over a", opA[0], 0);
        checkOutput("t4 select clears result", res[0], 0);

        $display("[TB] test 5: reset mid-op");
        press(K_SL);
        for (int i = 0; i < 5; i++) press(K_UP);
        press(K_RT);
        checkOutput("t5 in edit_b", eb[0], 1);
        #2 reset_n = 1'b0;
        btn_valid = 1'b0;
        modelReset();
        #1 checkAllZero("midreset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        press(K_UP);
        checkOutput("t5 first up after reset", opA[0], 1);

        $display("[TB] test 6: press during CALC");
        applyStimulus(1'b1, K_A);
        applyStimulus(1'b1, K_UP);
        applyStimulus(1'b1, K_UP);
        applyStimulus(1'b1, 7'h00);
        checkOutput("t6 operand unchanged", opA[0], 1);
        checkOutput("t6 in show", disp[0], 1);
        checkOutput("t6 not edit_b", eb[0], 0);

        $display("[TB] random phase");
        for (int i = 0; i < 1500; i++) begin
            rvld = ($urandom_range(0, 1) == 1);
            rb[0] = ($urandom_range(0, 99) < 35);
            rb[1] = ($urandom_range(0, 99) < 25);
            rb[2] = ($urandom_range(0, 99) < 15);
            rb[3] = ($urandom_range(0, 99) < 15);
            rb[4] = ($urandom_range(0, 99) < 4);
            rb[5] = ($urandom_range(0, 99) < 12);
            rb[6] = ($urandom_range(0, 99) < 12);
            applyStimulus(rvld, rb);
        end
        idle(4);
        checkOutput("poll queue drained", pollQ.size(), 0);
        checkOutput("result queue drained", resQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
